wfq_req_scheduler: RTL and testbench

Front-end controller for `wfq_engine`. It accepts rank-calculation requests from `NUM_REQ` ingress requesters and arbitrates among them round-robin. For each granted request it looks up the class weight in a configurable table, divides packet length by weight with a serial divider, and drives exactly one engine request at a time. It then returns the engine result to the granted requester. It sits between the per-port packet parsers and the PIFO rank datapath.

---
 rtl/wfq_pkg.sv | 23 ++
 rtl/wfq_div_serial.sv | 56 +++++
 rtl/wfq_req_scheduler.sv | 157 +++++++++++++++
 tb/tb_wfq_req_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wfq_pkg.sv
// wfq_req_scheduler shared types and defaults.
// FSM encoding, default widths, weight-zero quotient fill.
package wfq_pkg;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_CLASS_WIDTH  = 5;
  localparam int DEF_WEIGHT_WIDTH = 16;
  localparam int DEF_PKT_WIDTH    = 16;
  localparam int DEF_RESULT_WIDTH = 32;
  localparam int DEF_RESP_TIMEOUT = 15;

  // weight 0 saturates the quotient to all ones
  localparam logic WZ_QBIT = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/wfq_div_serial.sv
// Restoring serial divider, one quotient bit per cycle.
// done is high in the last iteration cycle; results hold afterwards.
module wfq_div_serial #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W);

  logic          run;
  logic [CW-1:0] cnt;
  logic [W-1:0]  quo;
  logic [W-1:0]  rem;
  logic [W-1:0]  dvs;
  logic [W:0]    trial;

  assign trial     = {rem, quo[W-1]};
  assign done      = run && (cnt == CW'(W - 1));
  assign quotient  = quo;
  assign remainder = rem;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      run <= 1'b0;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
      if (trial >= {1'b0, dvs}) begin
        rem <= W'(trial - {1'b0, dvs});
        quo <= {quo[W-2:0], 1'b1};
      end else begin
        rem <= trial[W-1:0];
        quo <= {quo[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/wfq_req_scheduler.sv
// Round-robin front end for wfq_engine: weight lookup,
// serial len/weight divide, single outstanding engine request.
module wfq_req_scheduler
  import wfq_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int CLASS_WIDTH  = DEF_CLASS_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int PKT_WIDTH    = DEF_PKT_WIDTH,
  parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
  parameter int RESP_TIMEOUT = DEF_RESP_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             in_valid,
  input  logic [NUM_REQ*CLASS_WIDTH-1:0] in_class_id,
  input  logic [NUM_REQ*PKT_WIDTH-1:0]   in_pkt_len,
  output logic [NUM_REQ-1:0]             in_ready,
  output logic [NUM_REQ-1:0]             out_valid,
  output logic [RESULT_WIDTH-1:0]        out_data,
  input  logic                           cfg_wr_en,
  input  logic [CLASS_WIDTH-1:0]         cfg_class_id,
  input  logic [WEIGHT_WIDTH-1:0]        cfg_weight,
  output logic                           eng_req_valid,
  output logic [CLASS_WIDTH-1:0]         eng_req_class_id,
  output logic [WEIGHT_WIDTH-1:0]        eng_req_div_quotient,
  output logic [WEIGHT_WIDTH-1:0]        eng_req_div_remain,
  input  logic                           eng_resp_valid,
  input  logic [RESULT_WIDTH-1:0]        eng_resp_data,
  output logic                           busy,
  output logic                           err_timeout
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int DEPTH = 1 << CLASS_WIDTH;
  localparam int TW    = $clog2(RESP_TIMEOUT + 1);

  state_t                  state;
  state_t                  state_nx;
  logic [IW-1:0]           last_grant;
  logic [IW-1:0]           idx_r;
  logic [IW-1:0]           win_idx;
  logic                    win_vld;
  logic                    accept;
  logic [CLASS_WIDTH-1:0]  cls_r;
  logic [CLASS_WIDTH-1:0]  win_cls;
  logic [PKT_WIDTH-1:0]    win_len;
  logic [WEIGHT_WIDTH-1:0] win_w;
  logic [WEIGHT_WIDTH-1:0] weight_tbl [DEPTH];
  logic                    wz_r;
  logic                    div_start;
  logic                    div_done;
  logic [WEIGHT_WIDTH-1:0] div_q;
  logic [WEIGHT_WIDTH-1:0] div_r;
  logic [TW-1:0]           tmo_cnt;
  logic                    tmo_hit;
  logic [RESULT_WIDTH-1:0] resp_r;
  logic                    err_r;
  logic                    eng_act;

  // search starts one past the last accepted requester
  always_comb begin : arb
    int            j;
    logic [IW-1:0] cand;
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(last_grant) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IW'(j);
      if (!win_vld && in_valid[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_cls   = in_class_id[win_idx*CLASS_WIDTH +: CLASS_WIDTH];
  assign win_len   = in_pkt_len[win_idx*PKT_WIDTH +: PKT_WIDTH];
  assign win_w     = weight_tbl[win_cls];
  assign accept    = (state == S_IDLE) && win_vld;
  assign in_ready  = accept ? (NUM_REQ'(1) << win_idx) : '0;
  assign div_start = accept && (win_w != '0);
  assign tmo_hit   = (tmo_cnt == TW'(RESP_TIMEOUT));

  wfq_div_serial #(
    .W (PKT_WIDTH)
  ) u_div (
    .clk       (clk),
    .rstn      (rstn),
    .start     (div_start),
    .dividend  (win_len),
    .divisor   (win_w),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept) state_nx = (win_w == '0) ? S_ISSUE : S_DIV;
      S_DIV:   if (div_done) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (eng_resp_valid || tmo_hit) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      idx_r      <= '0;
      cls_r      <= '0;
      wz_r       <= 1'b0;
      tmo_cnt    <= '0;
      resp_r     <= '0;
      err_r      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) weight_tbl[i] <= WEIGHT_WIDTH'(1);
    end else begin
      state <= state_nx;
      if (cfg_wr_en) weight_tbl[cfg_class_id] <= cfg_weight;
      if (accept) begin
        last_grant <= win_idx;
        idx_r      <= win_idx;
        cls_r      <= win_cls;
        wz_r       <= (win_w == '0);
      end
      if (state == S_ISSUE) tmo_cnt <= '0;
      else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      if (state == S_WAIT) begin
        if (eng_resp_valid) begin
          resp_r <= eng_resp_data;
        end else if (tmo_hit) begin
          resp_r <= '0;
          err_r  <= 1'b1;
        end
      end
    end
  end

  assign eng_act              = (state == S_ISSUE) || (state == S_WAIT);
  assign eng_req_valid        = (state == S_ISSUE);
  assign eng_req_class_id     = eng_act ? cls_r : '0;
  assign eng_req_div_quotient = !eng_act ? '0 :
                                wz_r ? {WEIGHT_WIDTH{WZ_QBIT}} : div_q;
  assign eng_req_div_remain   = (eng_act && !wz_r) ? div_r : '0;
  assign out_valid            = (state == S_RESP) ? (NUM_REQ'(1) << idx_r) : '0;
  assign out_data             = resp_r;
  assign busy                 = (state != S_IDLE);
  assign err_timeout          = err_r;

endmodule

// File: tb/tb_wfq_req_scheduler.sv
// Scoreboard bench for wfq_req_scheduler: grant order, divide
// results, engine/result latencies, timeout, cfg race, reset abort.
module tb_wfq_req_scheduler;

  localparam int NR = 4;
  localparam int CW = 5;
  localparam int WW = 16;
  localparam int PW = 16;
  localparam int RW = 32;
  localparam int RT = 15;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [NR-1:0]   in_valid = '0;
  logic [NR*CW-1:0] in_class_id = '0;
  logic [NR*PW-1:0] in_pkt_len = '0;
  logic [NR-1:0]   in_ready;
  logic [NR-1:0]   out_valid;
  logic [RW-1:0]   out_data;
  logic            cfg_wr_en = 1'b0;
  logic [CW-1:0]   cfg_class_id = '0;
  logic [WW-1:0]   cfg_weight = '0;
  logic            eng_req_valid;
  logic [CW-1:0]   eng_req_class_id;
  logic [WW-1:0]   eng_req_div_quotient;
  logic [WW-1:0]   eng_req_div_remain;
  logic            eng_resp_valid = 1'b0;
  logic [RW-1:0]   eng_resp_data = '0;
  logic            busy;
  logic            err_timeout;

  wfq_req_scheduler #(
    .NUM_REQ      (NR),
    .CLASS_WIDTH  (CW),
    .WEIGHT_WIDTH (WW),
    .PKT_WIDTH    (PW),
    .RESULT_WIDTH (RW),
    .RESP_TIMEOUT (RT)
  ) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .in_valid             (in_valid),
    .in_class_id          (in_class_id),
    .in_pkt_len           (in_pkt_len),
    .in_ready             (in_ready),
    .out_valid            (out_valid),
    .out_data             (out_data),
    .cfg_wr_en            (cfg_wr_en),
    .cfg_class_id         (cfg_class_id),
    .cfg_weight           (cfg_weight),
    .eng_req_valid        (eng_req_valid),
    .eng_req_class_id     (eng_req_class_id),
    .eng_req_div_quotient (eng_req_div_quotient),
    .eng_req_div_remain   (eng_req_div_remain),
    .eng_resp_valid       (eng_resp_valid),
    .eng_resp_data        (eng_resp_data),
    .busy                 (busy),
    .err_timeout          (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     req;
    int     cls;
    int     q;
    int     r;
    longint data;
    int     ilat;
    int     olat;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  bit          pending = 1'b0;
  bit          silent = 1'b0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          w_model[1<<CW];
  logic [RW-1:0] eng_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // scoreboard: grant on acceptance, request fields at ISSUE, result at RESP
  always @(negedge clk) begin
    logic [NR-1:0] a;
    if (!rstn) begin
      pending = 1'b0;
    end else begin
      a = in_valid & in_ready;
      if (a != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_grant", a, 0);
        end else begin
          cur = sb.pop_front();
          chk("grant", a, 64'(1 << cur.req));
          pending = 1'b1;
          acc_cyc = cyc;
        end
      end
      if (eng_req_valid) begin
        chk("eng_quotient", eng_req_div_quotient, 64'(cur.q));
        chk("eng_remain", eng_req_div_remain, 64'(cur.r));
        chk("eng_class", eng_req_class_id, 64'(cur.cls));
        chk("issue_latency", 64'(cyc - acc_cyc), 64'(cur.ilat));
      end
      if (out_valid != '0) begin
        if (!pending) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          chk("out_valid", out_valid, 64'(1 << cur.req));
          chk("out_data", out_data, 64'(cur.data));
          chk("out_latency", 64'(cyc - acc_cyc), 64'(cur.olat));
          pending = 1'b0;
        end
      end
    end
  end

  // engine model: fixed 3-cycle latency unless silent
  always begin
    @(negedge clk);
    if (rstn && eng_req_valid && !silent) begin
      eng_d = RW'(cur.data);
      repeat (3) @(posedge clk);
      #1;
      eng_resp_valid = 1'b1;
      eng_resp_data  = eng_d;
      @(posedge clk);
      #1;
      eng_resp_valid = 1'b0;
      eng_resp_data  = '0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int cls, input int len);
    in_class_id[i*CW +: CW] = CW'(cls);
    in_pkt_len[i*PW +: PW]  = PW'(len);
  endtask

  task automatic expect_req(input int req, input int cls, input int len,
                            input longint data);
    exp_t e;
    int   w;
    w     = w_model[cls];
    e.req = req;
    e.cls = cls;
    if (w == 0) begin
      e.q    = 16'hFFFF;
      e.r    = 0;
      e.ilat = 1;
    end else begin
      e.q    = len / w;
      e.r    = len % w;
      e.ilat = 17;
    end
    if (silent) begin
      e.data = 0;
      e.olat = e.ilat + 1 + RT + 1;
    end else begin
      e.data = data;
      e.olat = e.ilat + 4;
    end
    sb.push_back(e);
    set_req(req, cls, len);
  endtask

  task automatic cfg_write(input int cls, input int w);
    cfg_wr_en    = 1'b1;
    cfg_class_id = CW'(cls);
    cfg_weight   = WW'(w);
    step();
    cfg_wr_en    = 1'b0;
    w_model[cls] = w;
  endtask

  task automatic run_grants(input logic [NR-1:0] mask, input int n,
                            input bit held);
    logic [NR-1:0] a;
    int            cnt;
    int            budget;
    cnt      = 0;
    budget   = n * 80;
    in_valid = mask;
    while (cnt < n && budget > 0) begin
      @(negedge clk);
      a = in_valid & in_ready;
      if (a != '0) cnt++;
      step();
      cfg_wr_en = 1'b0;
      if (!held) in_valid = in_valid & ~a;
      else if (cnt >= n) in_valid = '0;
      budget--;
    end
    if (cnt < n) chk("grant_budget", 64'(cnt), 64'(n));
    in_valid = '0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy && !pending) done = 1'b1;
    end
    if (!done) chk("idle_budget", 0, 1);
    step();
  endtask

  initial begin
    for (int i = 0; i < (1 << CW); i++) w_model[i] = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_eng_valid", eng_req_valid, 0);
    chk("rst_eng_quot", eng_req_div_quotient, 0);
    chk("rst_err", err_timeout, 0);
    step();
    rstn = 1'b1;
    step();

    // basic divide 10/3 with engine round trip
    cfg_write(3, 3);
    expect_req(0, 3, 10, 64'h8000_5000);
    run_grants(4'b0001, 1, 1'b0);
    wait_idle();
    chk("no_err_yet", err_timeout, 0);

    // two contenders, each drops after its grant
    expect_req(1, 3, 11, 64'h1111_0001);
    expect_req(2, 5, 9, 64'h2222_0002);
    run_grants(4'b0110, 2, 1'b0);
    wait_idle();

    // weight-zero bypass
    cfg_write(7, 0);
    expect_req(0, 7, 100, 64'h0707_0064);
    run_grants(4'b0001, 1, 1'b0);
    wait_idle();

    // all four held: rotation 1,2,3,0,1
    expect_req(1, 1, 100, 64'hA000_0001);
    expect_req(2, 2, 33, 64'hA000_0002);
    expect_req(3, 3, 200, 64'hA000_0003);
    expect_req(0, 0, 77, 64'hA000_0000);
    expect_req(1, 1, 100, 64'hA000_0011);
    run_grants(4'b1111, 5, 1'b1);
    wait_idle();

    // silent engine: timeout, sticky error, late response ignored
    silent = 1'b1;
    expect_req(2, 4, 50, 64'hDEAD_BEEF);
    run_grants(4'b0100, 1, 1'b0);
    wait_idle();
    silent = 1'b0;
    chk("err_sticky", err_timeout, 1);
    eng_resp_valid = 1'b1;
    eng_resp_data  = 32'h5A5A_5A5A;
    step();
    eng_resp_valid = 1'b0;
    eng_resp_data  = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("late_out_valid", out_valid, 0);
      chk("late_busy", busy, 0);
      chk("late_err", err_timeout, 1);
    end
    step();

    // cfg write racing an acceptance uses the old weight
    cfg_wr_en    = 1'b1;
    cfg_class_id = CW'(2);
    cfg_weight   = WW'(5);
    expect_req(3, 2, 10, 64'hC0DE_0001);
    w_model[2] = 5;
    run_grants(4'b1000, 1, 1'b0);
    wait_idle();
    expect_req(3, 2, 10, 64'hC0DE_0002);
    run_grants(4'b1000, 1, 1'b0);
    wait_idle();

    // reset during DIV aborts the request
    expect_req(0, 3, 10, 64'hBAD0_0000);
    run_grants(4'b0001, 1, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rstn = 1'b0;
    sb.delete();
    for (int i = 0; i < (1 << CW); i++) w_model[i] = 1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_eng_valid", eng_req_valid, 0);
    end
    chk("abort_err_clr", err_timeout, 0);
    step();
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", out_valid, 0);
    end
    step();

    // after reset requester 0 wins first, weights back to 1
    expect_req(0, 3, 10, 64'hF00D_0000);
    expect_req(1, 1, 20, 64'hF00D_0001);
    run_grants(4'b1111, 2, 1'b1);
    wait_idle();
    chk("sb_drained", 64'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
